mem_port_arbiter: RTL and testbench

- Shares the single block-RAM memory port between the instruction-cache and data-cache miss/writeback engines.
- Latches one request at a time and drives the memory interface (address, Wr, din, Req_Low) for a fixed latency window.
- Returns the read block and a one-cycle active-low ready pulse to the granted requester.
- Sits between both cache controllers and the memory block.

---
 rtl/mem_port_arbiter.sv | 91 +++++++++
 tb/tb_mem_port_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one block-RAM port between the I-cache and D-cache engines,
// one latched transaction at a time, with a one-cycle active-low ready pulse back to the owner.
module mem_port_arbiter #(
  parameter int BLOCK_W     = 128,
  parameter int ADDR_W      = 10,
  parameter int MEM_LATENCY = 2,
  parameter int FIXED_PRIO  = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_req_low,
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic               i_wr,
  input  logic [BLOCK_W-1:0] i_din,
  output logic [BLOCK_W-1:0] i_dout,
  output logic               i_rdy_low,
  input  logic               d_req_low,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic               d_wr,
  input  logic [BLOCK_W-1:0] d_din,
  output logic [BLOCK_W-1:0] d_dout,
  output logic               d_rdy_low,
  output logic               mem_req_low,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [BLOCK_W-1:0] mem_din,
  output logic               mem_wr,
  input  logic [BLOCK_W-1:0] mem_dout,
  input  logic               mem_rdy_low,
  output logic               busy,
  output logic               grant
);
  localparam int CW = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic last;
  logic pick_d;
  // last = 1 means D was served most recently, so I wins the next tie
  always_comb pick_d = ~d_req_low & (i_req_low | (FIXED_PRIO != 0) | ~last);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      last        <= 1'b1;
      mem_req_low <= 1'b1;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= '0;
      i_rdy_low   <= 1'b1;
      d_rdy_low   <= 1'b1;
      i_dout      <= '0;
      d_dout      <= '0;
      busy        <= 1'b0;
      grant       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (!i_req_low || !d_req_low) begin
          grant       <= pick_d;
          mem_addr    <= pick_d ? d_addr : i_addr;
          mem_din     <= pick_d ? d_din : i_din;
          mem_wr      <= pick_d ? d_wr : i_wr;
          mem_req_low <= 1'b0;
          busy        <= 1'b1;
          cnt         <= CW'(MEM_LATENCY - 1);
          state       <= BUSY;
        end
        BUSY: if (!mem_rdy_low) begin
          if (cnt == '0) begin
            if (!mem_wr && grant) d_dout <= mem_dout;
            if (!mem_wr && !grant) i_dout <= mem_dout;
            mem_req_low <= 1'b1;
            mem_wr      <= 1'b0;
            i_rdy_low   <= grant;
            d_rdy_low   <= ~grant;
            state       <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          i_rdy_low <= 1'b1;
          d_rdy_low <= 1'b1;
          busy      <= 1'b0;
          last      <= grant;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a behavioural block-RAM model;
// a second FIXED_PRIO instance with both ports tied low shows D winning every arbitration.
module tb_mem_port_arbiter;
  localparam int BW = 128, AW = 10, LAT = 2;
  localparam logic [BW-1:0] PAT_A5 = {16{8'hA5}};
  localparam logic [BW-1:0] PAT_5A = {16{8'h5A}};
  localparam logic [BW-1:0] WDATA  = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic i_req_low = 1, i_wr = 0, d_req_low = 1, d_wr = 0, mem_rdy_low = 0;
  logic [AW-1:0] i_addr = '0, d_addr = '0, mem_addr, pre_addr = '0;
  logic [BW-1:0] i_din = '0, d_din = '0, i_dout, d_dout, mem_din, mem_dout, pre_data = '0;
  logic i_rdy_low, d_rdy_low, mem_req_low, mem_wr, busy, grant, pre_en = 0;
  logic [BW-1:0] mem [0:(1<<AW)-1];
  logic [BW-1:0] fp_i_dout, fp_d_dout, fp_mem_din;
  logic [AW-1:0] fp_mem_addr;
  logic fp_i_rdy_low, fp_d_rdy_low, fp_mem_req_low, fp_mem_wr, fp_busy, fp_grant;
  typedef struct {logic p; logic [BW-1:0] d;} sb_t;
  sb_t sb[$];
  int ntests = 0, nfail = 0;

  mem_port_arbiter #(.BLOCK_W(BW), .ADDR_W(AW), .MEM_LATENCY(LAT), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_low(i_req_low), .i_addr(i_addr), .i_wr(i_wr), .i_din(i_din), .i_dout(i_dout), .i_rdy_low(i_rdy_low),
    .d_req_low(d_req_low), .d_addr(d_addr), .d_wr(d_wr), .d_din(d_din), .d_dout(d_dout), .d_rdy_low(d_rdy_low),
    .mem_req_low(mem_req_low), .mem_addr(mem_addr), .mem_din(mem_din), .mem_wr(mem_wr),
    .mem_dout(mem_dout), .mem_rdy_low(mem_rdy_low), .busy(busy), .grant(grant));

  mem_port_arbiter #(.BLOCK_W(BW), .ADDR_W(AW), .MEM_LATENCY(LAT), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .i_req_low(1'b0), .i_addr(AW'(1)), .i_wr(1'b0), .i_din('0), .i_dout(fp_i_dout), .i_rdy_low(fp_i_rdy_low),
    .d_req_low(1'b0), .d_addr(AW'(2)), .d_wr(1'b0), .d_din('0), .d_dout(fp_d_dout), .d_rdy_low(fp_d_rdy_low),
    .mem_req_low(fp_mem_req_low), .mem_addr(fp_mem_addr), .mem_din(fp_mem_din), .mem_wr(fp_mem_wr),
    .mem_dout('0), .mem_rdy_low(1'b0), .busy(fp_busy), .grant(fp_grant));

  // registered-output RAM: read data appears the cycle after the address is presented
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (!mem_req_low) begin
      mem_dout <= mem[mem_addr];
      if (mem_wr) mem[mem_addr] <= mem_din;
    end
  end

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic txn(input logic p, input logic [AW-1:0] a, input logic w, input logic [BW-1:0] din,
                     input logic [BW-1:0] exp, input int exp_cyc, input int st, input bit wd);
    sb_t e;
    int cyc, wrc;
    logic [BW-1:0] other;
    cyc = 0;
    wrc = 0;
    other = p ? i_dout : d_dout;
    sb.push_back('{p, w ? (p ? d_dout : i_dout) : exp});
    if (p) begin d_addr = a; d_wr = w; d_din = din; d_req_low = 0; end
    else begin i_addr = a; i_wr = w; i_din = din; i_req_low = 0; end
    do begin
      @(negedge clk);
      cyc++;
      mem_rdy_low = (st > 0 && cyc < 1 + st);
      if (wd && cyc == 1) begin i_req_low = 1; d_req_low = 1; end
      if (i_rdy_low && d_rdy_low) begin
        chk("busy_mreq", mem_req_low, 0);
        chk("busy_maddr", mem_addr, a);
        chk("busy_mwr", mem_wr, w);
        chk("busy_flag", busy, 1);
        wrc += int'(mem_wr);
      end
    end while (i_rdy_low && d_rdy_low && cyc < 40);
    mem_rdy_low = 0;
    e = sb.pop_front();
    chk("rdy_seen", i_rdy_low & d_rdy_low, 0);
    chk("pulse_cyc", cyc, exp_cyc);
    chk("port", !d_rdy_low, e.p);
    chk("dout", e.p ? d_dout : i_dout, e.d);
    chk("other_dout", e.p ? i_dout : d_dout, other);
    chk("other_rdy", e.p ? i_rdy_low : d_rdy_low, 1);
    chk("resp_mem", {mem_req_low, mem_wr, busy}, 3'b101);
    chk("wr_cycles", wrc, w ? exp_cyc - 1 : 0);
    i_req_low = 1;
    d_req_low = 1;
    @(negedge clk);
    chk("idle_state", {busy, i_rdy_low, d_rdy_low}, 3'b011);
    @(negedge clk);
    chk("no_regrant", {mem_req_low, busy}, 2'b10);
  endtask

  initial begin
    sb_t e;
    int cyc;
    pre_en = 1;
    pre_addr = 10'h005; pre_data = PAT_A5; @(negedge clk);
    pre_addr = 10'h006; pre_data = PAT_5A; @(negedge clk);
    pre_en = 0;
    chk("rst_rdy", {i_rdy_low, d_rdy_low}, 2'b11);
    chk("rst_mem", {mem_req_low, mem_wr}, 2'b10);
    chk("rst_addr_din", {mem_addr, mem_din}, '0);
    chk("rst_douts", i_dout | d_dout, 0);
    chk("rst_busy_grant", {busy, grant}, 2'b00);

    // both ports request continuously from reset
    i_addr = 10'h005; d_addr = 10'h006; i_req_low = 0; d_req_low = 0;
    for (int k = 0; k < 4; k++) sb.push_back('{k[0], k[0] ? PAT_5A : PAT_A5});
    rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (i_rdy_low && d_rdy_low && cyc < 20);
      e = sb.pop_front();
      chk("rr_seen", i_rdy_low & d_rdy_low, 0);
      chk("rr_port", !d_rdy_low, e.p);
      chk("rr_grant", grant, e.p);
      chk("rr_dout", e.p ? d_dout : i_dout, e.d);
      chk("fp_port", {fp_i_rdy_low, fp_d_rdy_low}, 2'b10);
      chk("fp_grant", fp_grant, 1);
    end
    i_req_low = 1; d_req_low = 1;
    repeat (2) @(negedge clk);

    txn(0, 10'h005, 0, '0, PAT_A5, LAT + 1, 0, 0);
    txn(1, 10'h3FF, 1, WDATA, '0, LAT + 1, 0, 0);
    txn(0, 10'h3FF, 0, '0, WDATA, LAT + 1, 0, 0);
    txn(0, 10'h006, 0, '0, PAT_5A, LAT + 4, 3, 0);

    // reset in the second BUSY cycle of a D write
    d_addr = 10'h3FF; d_wr = 1; d_din = ~WDATA; d_req_low = 0;
    @(negedge clk);
    chk("pre_abort_wr", mem_wr, 1);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("abort_mem", {mem_req_low, mem_wr}, 2'b10);
    chk("abort_busy", busy, 0);
    d_req_low = 1; d_wr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_no_rdy", {d_rdy_low, i_rdy_low, busy}, 3'b110);
    end
    txn(0, 10'h005, 0, '0, PAT_A5, LAT + 1, 0, 0);

    txn(0, 10'h006, 0, '0, PAT_5A, LAT + 1, 0, 1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
